// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: LANES-wide pipeline register with valid/ready handshake,
// 2-entry skid buffer (head M, skid S), flush, empty-bundle squash and
// per-lane payload zeroing on the output.
module pipe_stage_skid_reg #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 512,
    parameter bit          SQUASH = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_vld,
    input  logic [LANES*DATA_W-1:0] in_payload,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_vld,
    output logic [LANES*DATA_W-1:0] out_payload,
    output logic [1:0]              occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nx;

    logic [LANES-1:0]        m_vld;
    logic [LANES-1:0]        s_vld;
    logic [LANES*DATA_W-1:0] m_data;
    logic [LANES*DATA_W-1:0] s_data;

    logic                    squashed;
    logic                    push;
    logic                    pop;
    logic                    ld_m;
    logic                    ld_s;
    logic                    shift_s;
    logic                    clr_m;

    // Handshake qualification: flush and empty bundles block the store.
    always_comb begin
        squashed  = SQUASH && (in_lane_vld == '0);
        push      = in_valid & in_ready & ~flush & ~squashed;
        out_valid = (state != EMPTY) & ~flush;
        pop       = out_valid & out_ready;
    end

    // Next-state and entry-load decode; flush overrides everything.
    always_comb begin
        state_nx = state;
        ld_m     = 1'b0;
        ld_s     = 1'b0;
        shift_s  = 1'b0;
        clr_m    = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nx = ONE;
                        ld_m     = 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_nx = TWO;
                        ld_s     = 1'b1;
                    end else if (push && pop) begin
                        ld_m     = 1'b1;
                    end else if (pop) begin
                        state_nx = EMPTY;
                        clr_m    = 1'b1;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nx = ONE;
                        shift_s  = 1'b1;
                    end
                end
                default: begin
                    state_nx = EMPTY;
                end
            endcase
        end
    end

    // State register; in_ready is registered from the next state so it never
    // depends combinationally on out_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx != TWO);
        end
    end

    // Entry storage: payload only changes on load or S->M shift, so unwritten
    // entries keep their reset zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_vld  <= '0;
            s_vld  <= '0;
            m_data <= '0;
            s_data <= '0;
        end else if (flush) begin
            m_vld  <= '0;
            s_vld  <= '0;
        end else begin
            if (ld_m) begin
                m_vld  <= in_lane_vld;
                m_data <= in_payload;
            end else if (shift_s) begin
                m_vld  <= s_vld;
                m_data <= s_data;
            end else if (clr_m) begin
                m_vld  <= '0;
            end
            if (ld_s) begin
                s_vld  <= in_lane_vld;
                s_data <= in_payload;
            end else if (shift_s) begin
                s_vld  <= '0;
            end
        end
    end

    // Output view of M: invalid lanes, EMPTY and flush cycles read as zero.
    always_comb begin
        out_lane_vld = out_valid ? m_vld : '0;
        out_payload  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (out_lane_vld[i]) begin
                out_payload[i*DATA_W +: DATA_W] = m_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Occupancy mirrors the state encoding.
    always_comb begin
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule
